// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: owns the PC and fetches into a valid/ready IF/ID register.
// One outstanding imem request; taken-branch redirects flush and refetch.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [31:0] buf_inst;
    logic [31:0] buf_pc;
    logic        id_valid;
    logic        drained;

    assign drained     = !id_valid || id_ready_i;
    // Gated by reset so no request leaks out while rst_i is held.
    assign imem_req_o  = (state == S_FETCH) && !rst_i;
    assign imem_addr_o = pc;
    assign id_valid_o  = id_valid;
    assign id_inst_o   = id_valid ? id_inst : NOP_INST;
    assign id_pc_o     = id_valid ? id_pc : 32'h0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
            id_pc    <= 32'h0;
            buf_inst <= 32'h0;
            buf_pc   <= 32'h0;
        end else if (redirect_i) begin
            pc       <= redirect_pc_i & 32'hFFFF_FFFC;
            id_valid <= 1'b0;
            if (state == S_WAIT && !imem_rvalid_i)
                state <= S_DROP;
            else
                state <= S_FETCH;
        end else begin
            if (id_valid && id_ready_i)
                id_valid <= 1'b0;
            unique case (state)
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        pc <= pc + 32'd4;
                        if (drained) begin
                            id_inst  <= imem_rdata_i;
                            id_pc    <= pc;
                            id_valid <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            buf_inst <= imem_rdata_i;
                            buf_pc   <= pc;
                            state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (drained) begin
                        id_inst  <= buf_inst;
                        id_pc    <= buf_pc;
                        id_valid <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid_i)
                        state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed scenarios plus random traffic against
// a program-order queue model of the fetch unit.
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .id_valid_o   (id_valid_o),
        .id_ready_i   (id_ready_i),
        .id_inst_o    (id_inst_o),
        .id_pc_o      (id_pc_o),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc;
    ent_t        q[$];
    logic [31:0] exp_pc;
    logic        pend;
    logic        pend_kill;
    int          pend_due;
    logic [31:0] pend_addr;
    int          lat_min;
    int          lat_max;
    logic        rnd_ready;
    logic        ready_val;
    logic        want_redir;
    int          redir_mode;
    logic [31:0] redir_pc;
    logic        redir_done;
    int          redir_cyc;
    int          redir_nreq;
    logic [31:0] req_log[$];
    int          req_cyc[$];
    int          consumed;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        id_ready_i    = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(id_valid_o), 32'd0);
        chk("rst_inst", id_inst_o, NOP);
        chk("rst_pc", id_pc_o, 32'h0);
        q.delete();
        req_log.delete();
        req_cyc.delete();
        pend       = 1'b0;
        pend_kill  = 1'b0;
        exp_pc     = RESET_PC;
        cyc        = 0;
        consumed   = 0;
        want_redir = 1'b0;
        redir_done = 1'b0;
        @(posedge clk);
        #1 rst_i = 1'b0;
    endtask

    task automatic step();
        logic        s_req, s_v, rv, rdy, rd, ok;
        logic [31:0] s_addr, s_inst, s_pc;
        int          lat;
        @(negedge clk);
        s_req  = imem_req_o;
        s_addr = imem_addr_o;
        s_v    = id_valid_o;
        s_inst = id_inst_o;
        s_pc   = id_pc_o;
        chk("id_valid", 32'(s_v), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("id_inst", s_inst, q[0].inst);
            chk("id_pc", s_pc, q[0].pc);
        end else begin
            chk("nop_inst", s_inst, NOP);
            chk("nop_pc", s_pc, 32'h0);
        end
        if (s_req) begin
            chk("req_addr", s_addr, exp_pc);
            chk("req_busy", 32'(pend), 32'd0);
        end
        rv  = pend && (cyc == pend_due);
        rdy = rnd_ready ? ($urandom_range(99) < 60) : ready_val;
        case (redir_mode)
            0:       ok = 1'b1;
            1:       ok = rv;
            default: ok = pend && !rv;
        endcase
        rd = want_redir && !s_req && !(pend && pend_kill) && ok;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem(pend_addr) : $urandom;
        id_ready_i    = rdy;
        redirect_i    = rd;
        redirect_pc_i = rd ? redir_pc : $urandom;
        if (s_v && rdy && !rd) begin
            void'(q.pop_front());
            consumed++;
        end
        if (s_req) begin
            lat       = $urandom_range(lat_max, lat_min);
            pend      = 1'b1;
            pend_kill = 1'b0;
            pend_addr = s_addr;
            pend_due  = cyc + lat;
            req_log.push_back(s_addr);
            req_cyc.push_back(cyc);
        end
        if (rv) begin
            pend = 1'b0;
            if (!pend_kill && !rd) begin
                q.push_back('{mem(pend_addr), pend_addr});
                exp_pc = pend_addr + 32'd4;
            end
        end
        if (rd) begin
            q.delete();
            exp_pc = redir_pc & 32'hFFFF_FFFC;
            if (pend && !rv) pend_kill = 1'b1;
            want_redir = 1'b0;
            redir_done = 1'b1;
            redir_cyc  = cyc;
            redir_nreq = req_log.size();
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic redirect_test(input int mode, input logic [31:0] tgt,
                                 input int lat, input int extra);
        do_reset();
        lat_min    = lat;
        lat_max    = lat;
        rnd_ready  = 1'b0;
        ready_val  = 1'b1;
        redir_mode = mode;
        redir_pc   = tgt;
        want_redir = 1'b1;
        for (int i = 0; i < 20 && !redir_done; i++) step();
        chk("redir_seen", 32'(redir_done), 32'd1);
        repeat (extra) step();
    endtask

    initial begin
        rnd_ready  = 1'b0;
        ready_val  = 1'b1;
        redir_mode = 0;
        redir_pc   = 32'h0;
        lat_min    = 1;
        lat_max    = 1;

        // 1: streaming at 1-cycle latency
        do_reset();
        repeat (8) step();
        chk("t1_nreq", 32'(req_log.size() >= 3), 32'd1);
        if (req_log.size() >= 3) begin
            chk("t1_a0", req_log[0], 32'h0);
            chk("t1_a1", req_log[1], 32'h4);
            chk("t1_a2", req_log[2], 32'h8);
            chk("t1_c0", 32'(req_cyc[0]), 32'd0);
            chk("t1_c1", 32'(req_cyc[1]), 32'd2);
            chk("t1_c2", 32'(req_cyc[2]), 32'd4);
        end
        chk("t1_consumed", 32'(consumed), 32'd3);

        // 2: decode stall fills the buffer
        do_reset();
        ready_val = 1'b0;
        repeat (8) step();
        chk("t2_noreq", 32'(req_log.size()), 32'd2);
        chk("t2_held_pc", id_pc_o, 32'h0);
        ready_val = 1'b1;
        repeat (2) step();
        chk("t2_nreq", 32'(req_log.size()), 32'd3);
        if (req_log.size() >= 3) begin
            chk("t2_a2", req_log[2], 32'h8);
            chk("t2_c2", 32'(req_cyc[2]), 32'd9);
        end
        chk("t2_consumed", 32'(consumed), 32'd2);

        // 3: redirect in WAIT with slow memory
        redirect_test(2, 32'h0000_0103, 3, 6);
        chk("t3_nreq", 32'(req_log.size() > redir_nreq), 32'd1);
        if (req_log.size() > redir_nreq) begin
            chk("t3_addr", req_log[redir_nreq], 32'h100);
            chk("t3_cyc", 32'(req_cyc[redir_nreq]), 32'(redir_cyc + 3));
        end

        // 4: redirect coincides with the response
        redirect_test(1, 32'h0000_0100, 1, 3);
        chk("t4_nreq", 32'(req_log.size() > redir_nreq), 32'd1);
        if (req_log.size() > redir_nreq) begin
            chk("t4_addr", req_log[redir_nreq], 32'h100);
            chk("t4_cyc", 32'(req_cyc[redir_nreq]), 32'(redir_cyc + 1));
        end

        // 5: PC wraps at the top of memory
        redirect_test(0, 32'hFFFF_FFFC, 1, 6);
        chk("t5_nreq", 32'(req_log.size() > redir_nreq + 1), 32'd1);
        if (req_log.size() > redir_nreq + 1) begin
            chk("t5_a0", req_log[redir_nreq], 32'hFFFF_FFFC);
            chk("t5_a1", req_log[redir_nreq + 1], 32'h0);
        end

        // 6: async reset while holding a buffered word
        do_reset();
        ready_val = 1'b0;
        repeat (6) step();
        chk("t6_pre_valid", 32'(id_valid_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("t6_req", 32'(imem_req_o), 32'd0);
        chk("t6_valid", 32'(id_valid_o), 32'd0);
        chk("t6_inst", id_inst_o, NOP);
        chk("t6_pc", id_pc_o, 32'h0);
        do_reset();
        ready_val = 1'b1;
        repeat (4) step();
        chk("t6_nreq", 32'(req_log.size() >= 1), 32'd1);
        if (req_log.size() >= 1) begin
            chk("t6_a0", req_log[0], RESET_PC);
            chk("t6_c0", 32'(req_cyc[0]), 32'd0);
        end

        // 7: random latency, stalls and redirects
        do_reset();
        lat_min   = 1;
        lat_max   = 4;
        rnd_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (!want_redir && $urandom_range(99) < 4) begin
                want_redir = 1'b1;
                redir_mode = 0;
                if ($urandom_range(3) == 0)
                    redir_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                else
                    redir_pc = $urandom;
            end
            step();
        end
        chk("t7_progress", 32'(consumed > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
